watch_set_ctrl: RTL and testbench
=================================

Name: watch_set_ctrl

Overview:
- Time-setting controller for the watch datapath.
- Toggles between RUN and SET modes from a mode pulse.
- In SET, converts debounced up/down button levels into single-cycle increment/decrement strobes for the field selected by the one-hot digit-position controller. Holding a button auto-repeats.
- Also gates the watch's 1 Hz advance and drives a blink enable for the display of the edited field.

Parameters:
- REPEAT_DELAY, 50_000_000: cycles from the first strobe of a hold to the first repeat strobe.
- REPEAT_RATE, 10_000_000: cycles between repeat strobes.
- TIMEOUT, 1_000_000_000: idle cycles in SET before automatic return to RUN.
- BLINK_HALF, 25_000_000: cycles per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_mode  in  1  one-cycle pulse; toggles RUN/SET
- i_up  in  1  debounced level, up button
- i_down  in  1  debounced level, down button
- i_digit_pos  in  3  one-hot field select: 001 sec, 010 min, 100 hour
- o_run_en  out  1  1 = watch counts time
- o_inc  out  3  one-cycle one-hot increment strobe per field
- o_dec  out  3  one-cycle one-hot decrement strobe per field
- o_sec_clr  out  1  one-cycle seconds-clear strobe
- o_set_mode  out  1  1 while in SET
- o_blink  out  1  display blink enable for the selected field

Behaviour:
- Reset values (asynchronous):
  - mode = RUN; repeat FSM = R_IDLE; all counters 0.
  - o_run_en = 1; o_set_mode = 0; o_blink = 0; o_inc = o_dec = 000; o_sec_clr = 0.
- All outputs are registered.
- Mode FSM (RUN, SET):
  - RUN: o_run_en = 1; i_up and i_down are ignored; i_mode -> SET.
  - SET: o_run_en = 0, o_set_mode = 1.
  - SET -> RUN on i_mode, or when the timeout counter reaches TIMEOUT-1.
  - The timeout counter clears on entry to SET, on every strobe, and while either button is high.
- Repeat FSM (active only in SET): R_IDLE, R_DELAY, R_REPEAT, R_LOCK.
  - R_IDLE: a rising edge is input low in cycle n-1 and high in cycle n.
    - Rising edge on exactly one button -> strobe issued in cycle n+1; go to R_DELAY with the counter cleared.
  - R_DELAY: same button still held and counter = REPEAT_DELAY-1 -> strobe; go to R_REPEAT, counter cleared.
  - R_REPEAT: strobe every REPEAT_RATE cycles while the button is held.
  - From R_DELAY or R_REPEAT, the active button releases -> R_IDLE.
  - Both buttons high in any state -> R_LOCK, no strobes; R_LOCK exits to R_IDLE only when both are low.
  - A mode change (either direction) forces R_LOCK if any button is high, otherwise R_IDLE.
- Strobe value:
  - o_inc (up) or o_dec (down) equals i_digit_pos sampled in the strobe's issue cycle.
  - If i_digit_pos is not exactly one-hot, no strobe is issued, but repeat timing still advances.
  - A field change mid-hold redirects subsequent strobes to the new field.
- o_inc and o_dec are never nonzero in the same cycle. Each strobe lasts exactly 1 cycle.
- Blink:
  - SET entry sets o_blink = 1; it then toggles every BLINK_HALF cycles.
  - o_blink is forced to 1 while the repeat FSM is in R_DELAY or R_REPEAT.
  - RUN forces o_blink to 0 and clears the blink counter.
- Counter widths are $clog2 of the largest parameter; the counters never wrap within a state.

Optional Feature:
- Macro: WATCH_SET_SEC_CLEAR_EN.
- Defined: any strobe that would target the seconds field (i_digit_pos = 001, up or down) instead pulses o_sec_clr for 1 cycle, and o_inc[0]/o_dec[0] stay 0. Auto-repeat is suppressed for seconds: the FSM goes to R_LOCK after the clear.
- Undefined: o_sec_clr is tied 0, and seconds increment and decrement like the other fields.

Test Plan:
Parameters for all scenarios: REPEAT_DELAY=8, REPEAT_RATE=3, TIMEOUT=50, BLINK_HALF=4.
1. Reset mid-SET while i_up is held -> o_run_en = 1, o_set_mode = 0, o_blink = 0, no strobes until a new i_mode pulse plus a fresh rising edge.
2. i_mode, then i_digit_pos = 010, i_up high from cycle 10 for 25 cycles -> o_inc = 010 at cycles 11, 19, 22, 25, 28, 31, 34; nothing after release.
3. In SET, i_down pulse 1 cycle with i_digit_pos = 100 -> exactly one o_dec = 100 one cycle later; no repeat.
4. Hold i_up, then assert i_down as well -> strobes stop; releasing only i_down gives no strobes; releasing both and pressing i_up again -> one strobe.
5. Enter SET, no input for 50 cycles -> return to RUN (o_run_en = 1) after cycle 50; o_blink toggles every 4 cycles while in SET.
6. With WATCH_SET_SEC_CLEAR_EN, i_digit_pos = 001, hold i_up 20 cycles -> single o_sec_clr pulse, o_inc stays 000. Without the macro -> o_inc = 001 at the repeat schedule of scenario 2.

Source files
------------

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: RUN/SET mode, button auto-repeat strobes, 1 Hz gating, field blink.
// Optional macro WATCH_SET_SEC_CLEAR_EN turns seconds strobes into a one-shot seconds clear.
module watch_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned TIMEOUT      = 1_000_000_000,
    parameter int unsigned BLINK_HALF   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mode,
    input  logic       i_up,
    input  logic       i_down,
    input  logic [2:0] i_digit_pos,
    output logic       o_run_en,
    output logic [2:0] o_inc,
    output logic [2:0] o_dec,
    output logic       o_sec_clr,
    output logic       o_set_mode,
    output logic       o_blink
);

    localparam int unsigned MAX_A = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned MAX_B = (TIMEOUT > BLINK_HALF) ? TIMEOUT : BLINK_HALF;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] DELAY_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST    = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] BLINK_LAST   = CW'(BLINK_HALF - 1);

    typedef enum logic {M_RUN, M_SET} mode_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT, R_LOCK} rep_t;

    mode_t         mode_q, mode_d;
    rep_t          rep_q, rep_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          ph_q, ph_d;
    logic          dir_q, dir_d;
    logic          up_q, down_q;
    logic          issue, issue_dn;
    logic [2:0]    inc_d, dec_d;
    logic          clr_d;
    logic          both_btn, any_btn, rise_up, rise_dn, held, one_hot;

    assign both_btn = i_up & i_down;
    assign any_btn  = i_up | i_down;
    assign rise_up  = i_up & ~up_q;
    assign rise_dn  = i_down & ~down_q;
    assign held     = dir_q ? i_down : i_up;
    assign one_hot  = (i_digit_pos == 3'b001) || (i_digit_pos == 3'b010) || (i_digit_pos == 3'b100);

    always_comb begin
        mode_d   = mode_q;
        rep_d    = rep_q;
        rcnt_d   = rcnt_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        ph_d     = ph_q;
        dir_d    = dir_q;
        issue    = 1'b0;
        issue_dn = 1'b0;
        inc_d    = '0;
        dec_d    = '0;
        clr_d    = 1'b0;

        if (mode_q == M_RUN) begin
            bcnt_d = '0;
            ph_d   = 1'b0;
            if (i_mode) begin
                mode_d = M_SET;
                rep_d  = any_btn ? R_LOCK : R_IDLE;
                rcnt_d = '0;
                tcnt_d = '0;
                ph_d   = 1'b1;
            end
        end else if (i_mode || (tcnt_q == TIMEOUT_LAST)) begin
            mode_d = M_RUN;
            rep_d  = any_btn ? R_LOCK : R_IDLE;
            rcnt_d = '0;
            tcnt_d = '0;
            bcnt_d = '0;
            ph_d   = 1'b0;
        end else begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d = '0;
                ph_d   = ~ph_q;
            end else begin
                bcnt_d = bcnt_q + CW'(1);
            end

            if (both_btn) begin
                rep_d  = R_LOCK;
                rcnt_d = '0;
            end else begin
                case (rep_q)
                    R_IDLE: begin
                        if (rise_up || rise_dn) begin
                            issue    = 1'b1;
                            issue_dn = rise_dn;
                            dir_d    = rise_dn;
                            rep_d    = R_DELAY;
                            rcnt_d   = '0;
                        end
                    end
                    R_DELAY: begin
                        if (!held) begin
                            rep_d  = R_IDLE;
                            rcnt_d = '0;
                        end else if (rcnt_q == DELAY_LAST) begin
                            issue    = 1'b1;
                            issue_dn = dir_q;
                            rep_d    = R_REPEAT;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + CW'(1);
                        end
                    end
                    R_REPEAT: begin
                        if (!held) begin
                            rep_d  = R_IDLE;
                            rcnt_d = '0;
                        end else if (rcnt_q == RATE_LAST) begin
                            issue    = 1'b1;
                            issue_dn = dir_q;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + CW'(1);
                        end
                    end
                    R_LOCK: begin
                        if (!any_btn) rep_d = R_IDLE;
                    end
                    default: rep_d = R_IDLE;
                endcase
            end

            // Non-one-hot field select still advances repeat timing; only the strobe is dropped.
            if (issue && one_hot) begin
`ifdef WATCH_SET_SEC_CLEAR_EN
                if (i_digit_pos[0]) begin
                    clr_d  = 1'b1;
                    rep_d  = R_LOCK;
                    rcnt_d = '0;
                end else if (issue_dn) begin
                    dec_d = i_digit_pos;
                end else begin
                    inc_d = i_digit_pos;
                end
`else
                if (issue_dn) dec_d = i_digit_pos;
                else          inc_d = i_digit_pos;
`endif
            end

            tcnt_d = (issue || any_btn) ? '0 : tcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= M_RUN;
            rep_q      <= R_IDLE;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            ph_q       <= 1'b0;
            dir_q      <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            o_run_en   <= 1'b1;
            o_set_mode <= 1'b0;
            o_blink    <= 1'b0;
            o_inc      <= '0;
            o_dec      <= '0;
            o_sec_clr  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            rep_q      <= rep_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            ph_q       <= ph_d;
            dir_q      <= dir_d;
            up_q       <= i_up;
            down_q     <= i_down;
            o_run_en   <= (mode_d == M_RUN);
            o_set_mode <= (mode_d == M_SET);
            o_blink    <= (mode_d == M_SET) && (ph_d || (rep_d == R_DELAY) || (rep_d == R_REPEAT));
            o_inc      <= inc_d;
            o_dec      <= dec_d;
            o_sec_clr  <= clr_d;
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: per-cycle expectations queued with stimulus, checked one edge later.
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_mode = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic [2:0] i_digit_pos = 3'b010;
    logic       o_run_en, o_sec_clr, o_set_mode, o_blink;
    logic [2:0] o_inc, o_dec;

    typedef struct packed {
        logic       run;
        logic [2:0] inc;
        logic [2:0] dec;
        logic       clr;
        logic       blink;
        logic       bcare;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    string tag = "reset";

    watch_set_ctrl #(
        .REPEAT_DELAY(8),
        .REPEAT_RATE (3),
        .TIMEOUT     (50),
        .BLINK_HALF  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (i_mode),
        .i_up       (i_up),
        .i_down     (i_down),
        .i_digit_pos(i_digit_pos),
        .o_run_en   (o_run_en),
        .o_inc      (o_inc),
        .o_dec      (o_dec),
        .o_sec_clr  (o_sec_clr),
        .o_set_mode (o_set_mode),
        .o_blink    (o_blink)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic run, input logic [2:0] inc, input logic [2:0] dec,
                                input logic clr, input logic blink, input logic bcare);
        exp_t e;
        e.run = run; e.inc = inc; e.dec = dec; e.clr = clr; e.blink = blink; e.bcare = bcare;
        return e;
    endfunction

    // Drive-cycle n issues a strobe when n is the press cycle s, s+8, then every 3 while held through e.
    function automatic bit strobe_at(input int n, input int s, input int e);
        return (n >= s) && (n <= e) && ((n == s) || ((n >= s + 8) && ((n - s - 8) % 3 == 0)));
    endfunction

    task automatic check_out();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty got=%0d exp=>0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (o_run_en === e.run) else begin
                bad++; $error("FAIL %s run_en got=%b exp=%b", tag, o_run_en, e.run);
            end
            total++;
            assert (o_set_mode === ~e.run) else begin
                bad++; $error("FAIL %s set_mode got=%b exp=%b", tag, o_set_mode, ~e.run);
            end
            total++;
            assert (o_inc === e.inc) else begin
                bad++; $error("FAIL %s inc got=%b exp=%b", tag, o_inc, e.inc);
            end
            total++;
            assert (o_dec === e.dec) else begin
                bad++; $error("FAIL %s dec got=%b exp=%b", tag, o_dec, e.dec);
            end
            total++;
            assert (o_sec_clr === e.clr) else begin
                bad++; $error("FAIL %s sec_clr got=%b exp=%b", tag, o_sec_clr, e.clr);
            end
            if (e.bcare) begin
                total++;
                assert (o_blink === e.blink) else begin
                    bad++; $error("FAIL %s blink got=%b exp=%b", tag, o_blink, e.blink);
                end
            end
        end
    endtask

    task automatic cyc(input logic m, input logic u, input logic d, input logic [2:0] pos, input exp_t e);
        i_mode = m; i_up = u; i_down = d; i_digit_pos = pos;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        exp_t e;
        logic [2:0] sec_inc;
        logic       sec_clr;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(ex(1, 3'b000, 3'b000, 0, 0, 1));
        check_out();
        rst = 1'b0;

        // 1: reset while SET and i_up held
        tag = "s1";
        cyc(1, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        cyc(0, 1, 0, 3'b010, ex(0, 3'b010, 3'b000, 0, 1, 1));
        cyc(0, 1, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        #2 rst = 1'b1;
        #1;
        tag = "s1_rst";
        sb.push_back(ex(1, 3'b000, 3'b000, 0, 0, 1));
        check_out();
        rst = 1'b0;
        tag = "s1_after";
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 3'b010, ex(1, 3'b000, 3'b000, 0, 0, 1));
        cyc(1, 1, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        for (int k = 0; k < 10; k++) cyc(0, 1, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(0, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(0, 1, 0, 3'b010, ex(0, 3'b010, 3'b000, 0, 1, 1));
        cyc(0, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(1, 0, 0, 3'b010, ex(1, 3'b000, 3'b000, 0, 0, 1));

        // 2: hold up on minutes, auto-repeat schedule
        tag = "s2";
        for (int c = 0; c <= 40; c++) begin
            e = ex(0, strobe_at(c, 10, 34) ? 3'b010 : 3'b000, 3'b000, 0, 1, (c >= 10 && c <= 34));
            cyc(c == 0, (c >= 10 && c <= 34), 0, 3'b010, e);
        end
        cyc(1, 0, 0, 3'b010, ex(1, 3'b000, 3'b000, 0, 0, 1));

        // 3: single down pulse on hours
        tag = "s3";
        cyc(1, 0, 0, 3'b100, ex(0, 3'b000, 3'b000, 0, 1, 1));
        cyc(0, 0, 0, 3'b100, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(0, 0, 1, 3'b100, ex(0, 3'b000, 3'b100, 0, 1, 1));
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 3'b100, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(1, 0, 0, 3'b100, ex(1, 3'b000, 3'b000, 0, 0, 1));

        // 4: both-button lockout
        tag = "s4";
        cyc(1, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        cyc(0, 1, 0, 3'b010, ex(0, 3'b010, 3'b000, 0, 1, 1));
        for (int k = 0; k < 2; k++) cyc(0, 1, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        for (int k = 0; k < 12; k++) cyc(0, 1, 1, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        for (int k = 0; k < 12; k++) cyc(0, 1, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(0, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(0, 1, 0, 3'b010, ex(0, 3'b010, 3'b000, 0, 1, 1));
        cyc(0, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(1, 0, 0, 3'b010, ex(1, 3'b000, 3'b000, 0, 0, 1));

        // 5: idle timeout and blink cadence
        tag = "s5";
        cyc(1, 0, 0, 3'b010, ex(0, 3'b000, 3'b000, 0, 1, 1));
        for (int c = 1; c <= 52; c++) begin
            if (c + 1 >= 51) e = ex(1, 3'b000, 3'b000, 0, 0, 1);
            else             e = ex(0, 3'b000, 3'b000, 0, (((c) / 4) % 2) == 0, 1);
            cyc(0, 0, 0, 3'b010, e);
        end

        // 6: seconds field, hold up 20 cycles
        tag = "s6";
        for (int c = 0; c <= 35; c++) begin
`ifdef WATCH_SET_SEC_CLEAR_EN
            sec_inc = 3'b000;
            sec_clr = (c == 10);
`else
            sec_inc = strobe_at(c, 10, 29) ? 3'b001 : 3'b000;
            sec_clr = 1'b0;
`endif
            cyc(c == 0, (c >= 10 && c <= 29), 0, 3'b001, ex(0, sec_inc, 3'b000, sec_clr, 0, 0));
        end
        cyc(1, 0, 0, 3'b001, ex(1, 3'b000, 3'b000, 0, 0, 1));

        // 7: non-one-hot select at press, field switched to hours mid-hold
        tag = "s7";
        cyc(1, 0, 0, 3'b011, ex(0, 3'b000, 3'b000, 0, 1, 1));
        for (int j = 0; j <= 9; j++)
            cyc(0, 1, 0, (j < 5) ? 3'b011 : 3'b100,
                ex(0, (j == 8) ? 3'b100 : 3'b000, 3'b000, 0, 1, 1));
        cyc(0, 0, 0, 3'b100, ex(0, 3'b000, 3'b000, 0, 0, 0));
        cyc(1, 0, 0, 3'b100, ex(1, 3'b000, 3'b000, 0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
